std_cache_bypass_arb: RTL and testbench
=======================================

Name: std_cache_bypass_arb

Overview:
- Round-robin arbiter sharing the single uncached/bypass port of the standard data cache among NR_PORTS requesters, e.g. load unit, store unit, AMO and miss-handler writeback.
- Each requester drives one bypass_req_t and receives one bypass_rsp_t.
- One transaction is in flight at a time: grant, then wait for the data/ack beat, then release.
- Sits between the cache controllers and the AXI/ACE adapter request port.

Parameters:
- NR_PORTS, 4, number of requesters; 2..16. Index width is IDX_W = $clog2(NR_PORTS).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; synchronous, active-high.
- req_i  input  NR_PORTS x bypass_req_t  per-requester bypass requests.
- rsp_o  output  NR_PORTS x bypass_rsp_t  per-requester gnt/valid/rdata.
- bypass_req_o  output  bypass_req_t  request to the shared adapter.
- bypass_rsp_i  input  bypass_rsp_t  adapter response: gnt, valid, rdata.
- busy_o  output  1  high while a transaction is owned, i.e. state != IDLE.

Behaviour:
- Interface: one clock (clk_i); rst_i is synchronous and active-high.
- Reset values: state=IDLE; rr_q=0; sel_q=0. All rsp_o fields are 0, bypass_req_o is all-zero, busy_o=0.
- State machine, states IDLE / REQ / WAIT_RSP:
  - IDLE: if any req_i[k].req, pick the winner by round-robin, searching upward from rr_q with wrap at NR_PORTS. Register sel_q=winner and go to REQ. Nothing is driven downstream in this cycle, so arbitration costs exactly 1 cycle.
  - REQ: bypass_req_o = req_i[sel_q], passed through combinationally with req forced to 1. On bypass_rsp_i.gnt, assert rsp_o[sel_q].gnt in the same cycle.
    - If bypass_rsp_i.valid is also high that cycle, also assert rsp_o[sel_q].valid with rdata, then go to IDLE.
    - Otherwise go to WAIT_RSP.
  - WAIT_RSP: bypass_req_o.req=0 and other fields 0. On bypass_rsp_i.valid, assert rsp_o[sel_q].valid with rdata=bypass_rsp_i.rdata, then go to IDLE.
- rr_q update: on every transition into IDLE, rr_q = (sel_q==NR_PORTS-1) ? 0 : sel_q+1. The just-served port therefore has lowest priority next.
- Non-selected ports see gnt=0, valid=0 and rdata=0. rsp_o[sel_q].rdata equals bypass_rsp_i.rdata only while valid is forwarded, and is 0 otherwise.
- Requester contract: hold req_i[k] stable with req=1 from assertion until gnt. Checked by a bench assertion; the RTL does not latch the payload.
- Dropped request: if req_i[sel_q].req falls while in REQ, it is a protocol error. The RTL returns to IDLE without forwarding the request and without updating rr_q.
- bypass_rsp_i.gnt or bypass_rsp_i.valid arriving in IDLE, or valid arriving in REQ without gnt, is ignored and routed to no port; a bench assertion flags it.
- Back-to-back: a port requesting continuously while others are idle is served every 3rd cycle (IDLE, REQ, WAIT_RSP) or every 2nd cycle when gnt and valid coincide.
- Reset mid-operation: state returns to IDLE and any outstanding transaction is abandoned. The adapter is reset in the same cycle by system convention.
- reqtype, acetype, amo, id, addr, wdata, we, be and size are forwarded unmodified.

Decomposition:
- bypass_req_t and bypass_rsp_t already live in std_cache_pkg.
- Add to std_cache_pkg: the arbiter state enum (IDLE/REQ/WAIT_RSP), typedef bypass_arb_state_t.
- Sub-module: std_cache_rr_pick, a combinational round-robin picker with inputs req vector and rr_q and outputs winner index and any_req. It is unit-testable on its own.

Test Plan:
- Single port 2 requests a read, addr=0x8000_0040; gnt after 2 cycles, valid with rdata=0xDEADBEEF_00C0FFEE 3 cycles later → rsp_o[2].gnt for 1 cycle, rsp_o[2].valid for 1 cycle with that rdata; ports 0, 1 and 3 stay all-zero.
- All 4 ports request continuously, with gnt and valid returned 1 cycle after each request → service order 0,1,2,3,0; each transaction occupies 2 cycles plus 1 cycle of IDLE arbitration.
- Ports 1 and 3 request while rr_q=2 → port 3 is served first, then port 1; rr_q=0 after port 3 and rr_q=2 after port 1.
- gnt and valid in the same cycle on port 0, AMO with amo=AMO_ADD → FSM goes REQ→IDLE directly; rsp_o[0].gnt=1 and rsp_o[0].valid=1 in the same cycle; busy_o lasts 1 cycle.
- rst_i asserted during WAIT_RSP for port 1, then a stray valid arrives the next cycle → all outputs 0, stray valid not forwarded, and the next request from port 0 is granted first (rr_q=0).
- Spurious bypass_rsp_i.valid in IDLE with no requests → every rsp_o field stays 0 and the state stays IDLE.

Source files
------------

// File: rtl/std_cache_pkg.sv
// rtl/std_cache_pkg.sv - shared types for the standard data cache bypass path
package std_cache_pkg;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int BE_W   = DATA_W / 8;
  localparam int ACE_W  = 4;

  typedef enum logic {
    SINGLE_REQ = 1'b0,
    BURST_REQ  = 1'b1
  } bypass_reqtype_t;

  typedef enum logic [3:0] {
    AMO_NONE = 4'd0,
    AMO_LR   = 4'd1,
    AMO_SC   = 4'd2,
    AMO_SWAP = 4'd3,
    AMO_ADD  = 4'd4,
    AMO_AND  = 4'd5,
    AMO_OR   = 4'd6,
    AMO_XOR  = 4'd7,
    AMO_MAX  = 4'd8,
    AMO_MAXU = 4'd9,
    AMO_MIN  = 4'd10,
    AMO_MINU = 4'd11
  } amo_t;

  typedef struct packed {
    logic               req;
    bypass_reqtype_t    reqtype;
    logic [ACE_W-1:0]   acetype;
    amo_t               amo;
    logic [ID_W-1:0]    id;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic               we;
    logic [BE_W-1:0]    be;
    logic [1:0]         size;
  } bypass_req_t;

  typedef struct packed {
    logic               gnt;
    logic               valid;
    logic [DATA_W-1:0]  rdata;
  } bypass_rsp_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } bypass_arb_state_t;

endpackage

// File: rtl/std_cache_rr_pick.sv
// rtl/std_cache_rr_pick.sv - combinational round-robin picker, searching upward from rr_q with wrap
module std_cache_rr_pick #(
  parameter int NR_PORTS = 4,
  parameter int IDX_W    = $clog2(NR_PORTS)
) (
  input  logic [NR_PORTS-1:0] req,
  input  logic [IDX_W-1:0]    rr_q,
  output logic [IDX_W-1:0]    winner,
  output logic                any_req
);

  int               cand;
  logic [IDX_W-1:0] idx;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    cand    = 0;
    idx     = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= NR_PORTS) cand = cand - NR_PORTS;
      idx = IDX_W'(cand);
      if (!any_req && req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/std_cache_bypass_arb.sv
// rtl/std_cache_bypass_arb.sv - round-robin arbiter for the single uncached/bypass port, one transaction in flight
module std_cache_bypass_arb
  import std_cache_pkg::*;
#(
  parameter int NR_PORTS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  bypass_req_t req_i [NR_PORTS],
  output bypass_rsp_t rsp_o [NR_PORTS],
  output bypass_req_t bypass_req_o,
  input  bypass_rsp_t bypass_rsp_i,
  output logic        busy_o
);

  localparam int IDX_W = $clog2(NR_PORTS);

  bypass_arb_state_t   state_q, state_d;
  logic [IDX_W-1:0]    rr_q, rr_d, sel_q, sel_d, winner, rr_next;
  logic [NR_PORTS-1:0] req_vec;
  logic                any_req;
  logic                fwd_gnt, fwd_valid;
  bypass_req_t         cur_req;

  always_comb begin
    req_vec = '0;
    cur_req = '0;
    for (int k = 0; k < NR_PORTS; k++) begin
      req_vec[k] = req_i[k].req;
      if (IDX_W'(k) == sel_q) cur_req = req_i[k];
    end
  end

  std_cache_rr_pick #(
    .NR_PORTS (NR_PORTS),
    .IDX_W    (IDX_W)
  ) u_rr_pick (
    .req     (req_vec),
    .rr_q    (rr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // The port just served drops to lowest priority.
  assign rr_next = (sel_q == IDX_W'(NR_PORTS - 1)) ? '0 : sel_q + IDX_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    rr_d         = rr_q;
    bypass_req_o = '0;
    fwd_gnt      = 1'b0;
    fwd_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d   = winner;
          state_d = REQ;
        end
      end
      REQ: begin
        // A requester withdrawing before gnt is abandoned without touching priority.
        if (!cur_req.req) begin
          state_d = IDLE;
        end else begin
          bypass_req_o     = cur_req;
          bypass_req_o.req = 1'b1;
          if (bypass_rsp_i.gnt) begin
            fwd_gnt = 1'b1;
            if (bypass_rsp_i.valid) begin
              fwd_valid = 1'b1;
              state_d   = IDLE;
              rr_d      = rr_next;
            end else begin
              state_d = WAIT_RSP;
            end
          end
        end
      end
      WAIT_RSP: begin
        if (bypass_rsp_i.valid) begin
          fwd_valid = 1'b1;
          state_d   = IDLE;
          rr_d      = rr_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < NR_PORTS; k++) begin
      rsp_o[k] = '0;
      if (IDX_W'(k) == sel_q) begin
        rsp_o[k].gnt   = fwd_gnt;
        rsp_o[k].valid = fwd_valid;
        rsp_o[k].rdata = fwd_valid ? bypass_rsp_i.rdata : '0;
      end
    end
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_std_cache_bypass_arb.sv
// tb/tb_std_cache_bypass_arb.sv - randomized and directed self-checking bench for std_cache_bypass_arb
module tb_std_cache_bypass_arb;
  import std_cache_pkg::*;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  bypass_req_t req_i [N];
  bypass_rsp_t rsp_o [N];
  bypass_req_t bypass_req_o;
  bypass_rsp_t bypass_rsp_i;
  logic        busy_o;

  std_cache_bypass_arb #(.NR_PORTS(N)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .rsp_o        (rsp_o),
    .bypass_req_o (bypass_req_o),
    .bypass_rsp_i (bypass_rsp_i),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: owner of the port (-1 when free), whether it still awaits gnt, next priority.
  int          m_owner = -1;
  bit          m_inreq = 1'b0;
  int          m_rr = 0;
  bypass_req_t e_req;
  bypass_rsp_t e_rsp [N];
  bit          e_busy;

  bit          pend [N];
  bit          sticky [N];
  bypass_req_t pl [N];
  int          arr_pct, drop_pct, amode;
  logic        m_gnt, m_valid;
  logic [63:0] m_rdata;

  int          cyc = 0;
  int          order_q[$];
  int          order_cyc[$];
  int          gnt_cnt [N];
  int          val_cnt [N];
  int          g_cyc [N];
  int          v_cyc [N];
  logic [63:0] last_rdata [N];
  int          busy_cnt;

  function automatic bypass_req_t rand_payload();
    bypass_req_t p;
    p.req     = 1'b1;
    p.reqtype = bypass_reqtype_t'($urandom_range(0, 1));
    p.acetype = 4'($urandom);
    p.amo     = amo_t'($urandom_range(0, 11));
    p.id      = 4'($urandom);
    p.addr    = {$urandom, $urandom};
    p.wdata   = {$urandom, $urandom};
    p.we      = 1'($urandom);
    p.be      = 8'($urandom);
    p.size    = 2'($urandom);
    return p;
  endfunction

  task automatic clear_obs();
    order_q.delete();
    order_cyc.delete();
    busy_cnt = 0;
    for (int k = 0; k < N; k++) begin
      gnt_cnt[k] = 0; val_cnt[k] = 0; g_cyc[k] = -1; v_cyc[k] = -1; last_rdata[k] = '0;
    end
  endtask

  task automatic model_eval();
    e_req  = '0;
    for (int k = 0; k < N; k++) e_rsp[k] = '0;
    e_busy = (m_owner >= 0);
    if (m_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        int p;
        p = (m_rr + i) % N;
        if (req_i[p].req) begin
          m_owner = p;
          m_inreq = 1'b1;
          break;
        end
      end
    end else if (m_inreq) begin
      if (!req_i[m_owner].req) begin
        m_owner = -1;
      end else begin
        e_req = req_i[m_owner];
        e_req.req = 1'b1;
        if (bypass_rsp_i.gnt) begin
          e_rsp[m_owner].gnt = 1'b1;
          if (bypass_rsp_i.valid) begin
            e_rsp[m_owner].valid = 1'b1;
            e_rsp[m_owner].rdata = bypass_rsp_i.rdata;
            m_rr = (m_owner + 1) % N;
            m_owner = -1;
          end else begin
            m_inreq = 1'b0;
          end
        end
      end
    end else if (bypass_rsp_i.valid) begin
      e_rsp[m_owner].valid = 1'b1;
      e_rsp[m_owner].rdata = bypass_rsp_i.rdata;
      m_rr = (m_owner + 1) % N;
      m_owner = -1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (!pend[k] && ($urandom_range(0, 99) < arr_pct)) begin
        pend[k] = 1'b1;
        pl[k] = rand_payload();
      end else if (pend[k] && ($urandom_range(0, 99) < drop_pct)) begin
        pend[k] = 1'b0;
      end
      req_i[k] = pend[k] ? pl[k] : '0;
    end
    bypass_rsp_i = '0;
    case (amode)
      0: begin
        bypass_rsp_i.gnt   = ($urandom_range(0, 99) < 45);
        bypass_rsp_i.valid = ($urandom_range(0, 99) < 35);
      end
      1: begin
        bypass_rsp_i.gnt   = (m_owner >= 0) && m_inreq;
        bypass_rsp_i.valid = (m_owner >= 0) && !m_inreq;
      end
      2: begin
        bypass_rsp_i.gnt   = (m_owner >= 0) && m_inreq;
        bypass_rsp_i.valid = (m_owner >= 0) && m_inreq;
      end
      default: begin
        bypass_rsp_i.gnt   = m_gnt;
        bypass_rsp_i.valid = m_valid;
      end
    endcase
    bypass_rsp_i.rdata = (amode == 3) ? m_rdata : {$urandom, $urandom};
    #2;
    model_eval();
    check("busy", 256'(busy_o), 256'(e_busy));
    check("bypass_req", 256'(bypass_req_o), 256'(e_req));
    for (int k = 0; k < N; k++) begin
      check($sformatf("rsp%0d", k), 256'(rsp_o[k]), 256'(e_rsp[k]));
      if (rsp_o[k].gnt) begin
        gnt_cnt[k]++; g_cyc[k] = cyc;
        order_q.push_back(k); order_cyc.push_back(cyc);
      end
      if (rsp_o[k].valid) begin
        val_cnt[k]++; v_cyc[k] = cyc; last_rdata[k] = rsp_o[k].rdata;
      end
      if (e_rsp[k].gnt && !sticky[k]) pend[k] = 1'b0;
    end
    if (busy_o) busy_cnt++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    bypass_rsp_i = '0;
    m_owner = -1;
    m_inreq = 1'b0;
    m_rr = 0;
  endtask

  function automatic int order_at(int i);
    return (i < order_q.size()) ? order_q[i] : -1;
  endfunction

  initial begin
    rst_i = 1'b1;
    bypass_rsp_i = '0;
    for (int k = 0; k < N; k++) begin
      req_i[k] = '0; pend[k] = 1'b0; sticky[k] = 1'b0; pl[k] = '0;
    end
    arr_pct = 0; drop_pct = 0; amode = 3;
    m_gnt = 1'b0; m_valid = 1'b0; m_rdata = '0;
    clear_obs();

    // Reset state
    do_reset();
    cycle(); cycle();

    // Single read on port 2 with delayed gnt and valid
    do_reset(); clear_obs();
    pl[2] = rand_payload();
    pl[2].addr = 64'h8000_0040; pl[2].we = 1'b0; pl[2].amo = AMO_NONE;
    pend[2] = 1'b1;
    m_rdata = 64'hDEAD_BEEF_00C0_FFEE;
    for (int c = 0; c < 8; c++) begin
      m_gnt = (c == 2); m_valid = (c == 5);
      cycle();
    end
    m_gnt = 1'b0; m_valid = 1'b0;
    check("t1_gnt_cnt", 256'(gnt_cnt[2]), 256'(1));
    check("t1_val_cnt", 256'(val_cnt[2]), 256'(1));
    check("t1_rdata", 256'(last_rdata[2]), 256'(64'hDEAD_BEEF_00C0_FFEE));
    check("t1_others", 256'(gnt_cnt[0] + gnt_cnt[1] + gnt_cnt[3] + val_cnt[0] + val_cnt[1] + val_cnt[3]), 256'(0));

    // All ports continuously requesting: strict rotation, 3 cycles per transaction
    do_reset(); clear_obs();
    amode = 1;
    for (int k = 0; k < N; k++) begin
      sticky[k] = 1'b1; pend[k] = 1'b1; pl[k] = rand_payload();
    end
    repeat (16) cycle();
    for (int i = 0; i < 5; i++) check($sformatf("t2_order%0d", i), 256'(order_at(i)), 256'(i % N));
    check("t2_spacing", 256'((order_cyc.size() >= 2) ? order_cyc[1] - order_cyc[0] : -1), 256'(3));
    for (int k = 0; k < N; k++) begin
      sticky[k] = 1'b0; pend[k] = 1'b0;
    end

    // Ports 1 and 3 with rr at 2: 3 first, then 1; afterwards 2 beats 1
    do_reset(); clear_obs();
    pl[1] = rand_payload(); pend[1] = 1'b1;
    repeat (3) cycle();
    clear_obs();
    pl[1] = rand_payload(); pend[1] = 1'b1;
    pl[3] = rand_payload(); pend[3] = 1'b1;
    repeat (7) cycle();
    check("t3_first", 256'(order_at(0)), 256'(3));
    check("t3_second", 256'(order_at(1)), 256'(1));
    clear_obs();
    pl[1] = rand_payload(); pend[1] = 1'b1;
    pl[2] = rand_payload(); pend[2] = 1'b1;
    repeat (4) cycle();
    check("t3_rr_after1", 256'(order_at(0)), 256'(2));
    repeat (4) cycle();

    // AMO with gnt and valid together
    do_reset(); clear_obs();
    amode = 2;
    pl[0] = rand_payload(); pl[0].amo = AMO_ADD; pl[0].we = 1'b1; pend[0] = 1'b1;
    repeat (4) cycle();
    check("t4_gnt", 256'(gnt_cnt[0]), 256'(1));
    check("t4_valid", 256'(val_cnt[0]), 256'(1));
    check("t4_same_cyc", 256'(g_cyc[0] - v_cyc[0]), 256'(0));
    check("t4_busy_len", 256'(busy_cnt), 256'(1));

    // Reset during WAIT_RSP then a stray valid
    do_reset(); clear_obs();
    amode = 3; m_valid = 1'b0;
    pl[1] = rand_payload(); pend[1] = 1'b1;
    m_gnt = 1'b0; cycle();
    m_gnt = 1'b1; cycle();
    m_gnt = 1'b0; cycle();
    check("t5_in_wait", 256'(busy_o), 256'(1));
    do_reset(); clear_obs();
    m_valid = 1'b1; m_rdata = 64'h1234_5678_9ABC_DEF0;
    cycle();
    m_valid = 1'b0;
    check("t5_stray", 256'(val_cnt[1] + busy_cnt), 256'(0));
    amode = 1;
    pl[0] = rand_payload(); pend[0] = 1'b1;
    pl[1] = rand_payload(); pend[1] = 1'b1;
    repeat (7) cycle();
    check("t5_first", 256'(order_at(0)), 256'(0));

    // Spurious gnt/valid in IDLE with no requesters
    do_reset(); clear_obs();
    amode = 3; m_gnt = 1'b1; m_valid = 1'b1;
    repeat (3) cycle();
    m_gnt = 1'b0; m_valid = 1'b0;
    check("t6_quiet", 256'(val_cnt[0] + val_cnt[1] + val_cnt[2] + val_cnt[3] + busy_cnt), 256'(0));

    // Randomized traffic with occasional drops and resets
    do_reset(); clear_obs();
    amode = 0; arr_pct = 30; drop_pct = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
